// File: rtl/cv_pkg.sv
// cv_pkg: shared types and helpers for the candy vending controller.
//   NICKEL_VAL/DIME_VAL/QUARTER_VAL : coin values in cents
//   cv_state_t                      : controller FSM states
//   coin_value()                    : cents for a single coin, 0 if the combination is illegal
package cv_pkg;

    localparam int NICKEL_VAL  = 5;
    localparam int DIME_VAL    = 10;
    localparam int QUARTER_VAL = 25;

    typedef enum logic [1:0] {IDLE, CREDIT, VEND, CHANGE} cv_state_t;

    function automatic logic [4:0] coin_value(input logic nickel, input logic dime, input logic quarter);
        case ({nickel, dime, quarter})
            3'b100:  coin_value = 5'(NICKEL_VAL);
            3'b010:  coin_value = 5'(DIME_VAL);
            3'b001:  coin_value = 5'(QUARTER_VAL);
            default: coin_value = 5'd0;
        endcase
    endfunction

endpackage

// File: rtl/candy_vending_ctrl_p_if.sv
// candy_vending_ctrl_p_if: customer-side handshake of the vending controller.
//   master : drives coin/cancel/sel/restock pulses, observes change and vend outputs
//   slave  : the controller side
// With CV_REVENUE_CNT_EN defined the bundle also carries the 16-bit revenue counter.
interface candy_vending_ctrl_p_if #(
    parameter int SEL_W = 2
);
    logic             nickel;
    logic             dime;
    logic             quarter;
    logic             cancel;
    logic [SEL_W-1:0] sel;
    logic             restock;
    logic             n;
    logic             d;
    logic             candy;
    logic [SEL_W-1:0] vend_slot;
    logic             sold_out;
    logic             coin_err;
    logic             busy;
`ifdef CV_REVENUE_CNT_EN
    logic [15:0]      revenue;
`endif

    modport master (
        output nickel, dime, quarter, cancel, sel, restock,
        input  n, d, candy, vend_slot, sold_out, coin_err, busy
`ifdef CV_REVENUE_CNT_EN
        , input revenue
`endif
    );

    modport slave (
        input  nickel, dime, quarter, cancel, sel, restock,
        output n, d, candy, vend_slot, sold_out, coin_err, busy
`ifdef CV_REVENUE_CNT_EN
        , output revenue
`endif
    );

endinterface

// File: rtl/cv_change_dispenser.sv
// cv_change_dispenser: serial greedy change output.
//   clock, reset : clock, synchronous active-high reset
//   load         : capture remainder (cents, multiple of 5)
//   remainder    : amount to pay out
//   n, d         : registered nickel / dime pulse, at most one per cycle
//   done         : high while the pulse being issued this cycle is the last one
module cv_change_dispenser #(
    parameter int W = 5
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] remainder,
    output logic         n,
    output logic         d,
    output logic         done
);

    logic [W-1:0] rem;

    // Remainders are multiples of 5, so 5 or 10 left means one pulse finishes the job.
    assign done = (rem == W'(5)) || (rem == W'(10));

    always_ff @(posedge clock) begin
        if (reset) begin
            rem <= '0;
            n   <= 1'b0;
            d   <= 1'b0;
        end else begin
            n <= 1'b0;
            d <= 1'b0;
            if (load) begin
                rem <= remainder;
            end else if (rem >= W'(10)) begin
                d   <= 1'b1;
                rem <= rem - W'(10);
            end else if (rem == W'(5)) begin
                n   <= 1'b1;
                rem <= '0;
            end
        end
    end

endmodule

// File: rtl/candy_vending_ctrl_p.sv
// candy_vending_ctrl_p: parametrised candy vending controller.
//   clock, reset : clock, synchronous active-high reset
//   vif (slave)  : nickel/dime/quarter/cancel/restock pulses and sel in;
//                  candy/vend_slot/sold_out/coin_err/busy and serial n/d change out
// Optional: define CV_REVENUE_CNT_EN to add vif.revenue, a wrapping 16-bit sum of
// PRICE per vended item.
module candy_vending_ctrl_p
    import cv_pkg::*;
#(
    parameter int PRICE      = 15,
    parameter int NUM_SLOTS  = 4,
    parameter int STOCK_INIT = 8,
    parameter int SEL_W      = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1,
    parameter int STOCK_W    = $clog2(STOCK_INIT + 1)
) (
    input  logic                   clock,
    input  logic                   reset,
    candy_vending_ctrl_p_if.slave  vif
);

    localparam int CW = $clog2(PRICE + 21);
    typedef logic [CW-1:0] credit_t;

    cv_state_t          state;
    credit_t            credit;
    logic [STOCK_W-1:0] stock [NUM_SLOTS];

    logic       any_coin, multi_coin, stock_ok, chg_load, chg_done;
    logic [4:0] cval;
    credit_t    credit_sum, vend_rem, chg_val;

    assign any_coin   = vif.nickel | vif.dime | vif.quarter;
    assign multi_coin = (vif.nickel & vif.dime) | (vif.nickel & vif.quarter) | (vif.dime & vif.quarter);
    assign cval       = coin_value(vif.nickel, vif.dime, vif.quarter);
    assign credit_sum = credit + credit_t'(cval);

    // Loop compare keeps an out-of-range sel from indexing past the stock array;
    // such a select simply never matches and falls out as sold-out.
    always_comb begin
        stock_ok = 1'b0;
        for (int i = 0; i < NUM_SLOTS; i++)
            if (int'(vif.sel) == i && stock[i] != '0) stock_ok = 1'b1;
    end

    assign vend_rem = stock_ok ? credit - credit_t'(PRICE) : credit;

    // The dispenser loads on the same edge the FSM enters CHANGE, so its first
    // pulse lands in the very next cycle.
    assign chg_load = (state == VEND) || (state == CREDIT && vif.cancel);
    assign chg_val  = (state == VEND) ? vend_rem : credit;

    cv_change_dispenser #(.W(CW)) u_change (
        .clock     (clock),
        .reset     (reset),
        .load      (chg_load),
        .remainder (chg_val),
        .n         (vif.n),
        .d         (vif.d),
        .done      (chg_done)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            credit        <= '0;
            vif.candy     <= 1'b0;
            vif.vend_slot <= '0;
            vif.sold_out  <= 1'b0;
            vif.coin_err  <= 1'b0;
            vif.busy      <= 1'b0;
            for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
`ifdef CV_REVENUE_CNT_EN
            vif.revenue   <= '0;
`endif
        end else begin
            vif.candy    <= 1'b0;
            vif.sold_out <= 1'b0;
            vif.coin_err <= 1'b0;
            case (state)
                IDLE, CREDIT: begin
                    vif.busy <= 1'b0;
                    if (state == IDLE && vif.restock)
                        for (int i = 0; i < NUM_SLOTS; i++) stock[i] <= STOCK_W'(STOCK_INIT);
                    if (vif.cancel) begin
                        // cancel takes priority; any coin with it is bounced
                        if (any_coin) vif.coin_err <= 1'b1;
                        if (state == CREDIT) begin
                            credit   <= '0;
                            state    <= CHANGE;
                            vif.busy <= 1'b1;
                        end
                    end else if (multi_coin) begin
                        vif.coin_err <= 1'b1;
                    end else if (any_coin) begin
                        credit <= credit_sum;
                        if (credit_sum >= credit_t'(PRICE)) begin
                            state    <= VEND;
                            vif.busy <= 1'b1;
                        end else begin
                            state <= CREDIT;
                        end
                    end
                end
                VEND: begin
                    if (any_coin) vif.coin_err <= 1'b1;
                    if (stock_ok) begin
                        vif.candy     <= 1'b1;
                        vif.vend_slot <= vif.sel;
                        for (int i = 0; i < NUM_SLOTS; i++)
                            if (int'(vif.sel) == i) stock[i] <= stock[i] - STOCK_W'(1);
`ifdef CV_REVENUE_CNT_EN
                        vif.revenue <= vif.revenue + 16'(PRICE);
`endif
                    end else begin
                        vif.sold_out <= 1'b1;
                    end
                    credit   <= '0;
                    state    <= (vend_rem != '0) ? CHANGE : IDLE;
                    vif.busy <= (vend_rem != '0);
                end
                CHANGE: begin
                    if (any_coin) vif.coin_err <= 1'b1;
                    if (chg_done) begin
                        state    <= IDLE;
                        vif.busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_candy_vending_ctrl_p.sv
// Bench for candy_vending_ctrl_p: directed scenarios then random pulses, all
// checked cycle by cycle against a timeline model of expected outputs.
module tb_candy_vending_ctrl_p;

    localparam int PRICE = 15, NUM_SLOTS = 3, STOCK_INIT = 2, SEL_W = 2;
    localparam int NCYC = 4096;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    candy_vending_ctrl_p_if #(.SEL_W(SEL_W)) vif();

    candy_vending_ctrl_p #(
        .PRICE(PRICE), .NUM_SLOTS(NUM_SLOTS), .STOCK_INIT(STOCK_INIT), .SEL_W(SEL_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .vif   (vif)
    );

    int total = 0, bad = 0, cyc = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, act, exp);
        end
    endtask

    // Expected outputs per edge index; the model writes future entries when it
    // schedules a vend or a run of change pulses.
    bit e_n[NCYC], e_d[NCYC], e_candy[NCYC], e_sold[NCYC], e_err[NCYC], e_busy[NCYC];
    int e_slot[NCYC], e_rev[NCYC];
    int credit, free_at, vend_at, rev;
    int stock[NUM_SLOTS];

    function automatic void sched(int k, int r);
        int j = 0;
        while (r >= 10) begin e_d[k+1+j] = 1; r -= 10; j++; end
        if (r == 5) begin e_n[k+1+j] = 1; j++; end
        for (int b = 0; b < j; b++) e_busy[k+b] = 1;
        free_at = k + j + 1;
    endfunction

    function automatic void model_edge(int k, bit rst, bit nk, bit dm, bit qt, bit cn, bit rs, int s);
        int cnt = int'(nk) + int'(dm) + int'(qt);
        if (rst) begin
            for (int j = k; j < k + 16 && j < NCYC; j++) begin
                e_n[j] = 0; e_d[j] = 0; e_candy[j] = 0; e_sold[j] = 0; e_err[j] = 0; e_busy[j] = 0;
            end
            credit = 0; free_at = 0; vend_at = -1; rev = 0;
            for (int i = 0; i < NUM_SLOTS; i++) stock[i] = STOCK_INIT;
        end else if (k < free_at) begin
            if (cnt > 0) e_err[k] = 1;
            if (vend_at == k) begin
                if (s < NUM_SLOTS && stock[s] > 0) begin
                    e_candy[k] = 1; e_slot[k] = s; stock[s]--;
                    rev = (rev + PRICE) % 65536;
                    sched(k, credit - PRICE);
                end else begin
                    e_sold[k] = 1;
                    sched(k, credit);
                end
                credit = 0; vend_at = -1;
            end
        end else begin
            if (rs && credit == 0)
                for (int i = 0; i < NUM_SLOTS; i++) stock[i] = STOCK_INIT;
            if (cn) begin
                if (cnt > 0) e_err[k] = 1;
                if (credit > 0) begin
                    int r = credit;
                    credit = 0;
                    sched(k, r);
                end
            end else if (cnt > 1) begin
                e_err[k] = 1;
            end else if (cnt == 1) begin
                credit += nk ? 5 : (dm ? 10 : 25);
                if (credit >= PRICE) begin
                    vend_at = k + 1; free_at = k + 2; e_busy[k] = 1;
                end
            end
        end
        e_rev[k] = rev;
    endfunction

    task automatic step(bit rst, bit nk, bit dm, bit qt, bit cn, bit rs, int s);
        logic [31:0] sv = s;
        reset = rst; vif.nickel = nk; vif.dime = dm; vif.quarter = qt;
        vif.cancel = cn; vif.restock = rs; vif.sel = sv[SEL_W-1:0];
        model_edge(cyc, rst, nk, dm, qt, cn, rs, s);
        @(posedge clock); #1;
        chk("n",        32'(vif.n),        32'(e_n[cyc]));
        chk("d",        32'(vif.d),        32'(e_d[cyc]));
        chk("candy",    32'(vif.candy),    32'(e_candy[cyc]));
        chk("sold_out", 32'(vif.sold_out), 32'(e_sold[cyc]));
        chk("coin_err", 32'(vif.coin_err), 32'(e_err[cyc]));
        chk("busy",     32'(vif.busy),     32'(e_busy[cyc]));
        if (e_candy[cyc]) chk("vend_slot", 32'(vif.vend_slot), 32'(e_slot[cyc]));
`ifdef CV_REVENUE_CNT_EN
        chk("revenue",  32'(vif.revenue),  32'(e_rev[cyc]));
`endif
        cyc++;
    endtask

    task automatic idle(int cycles, int s);
        for (int i = 0; i < cycles; i++) step(0, 0, 0, 0, 0, 0, s);
    endtask

    initial begin
        step(1, 0, 0, 0, 0, 0, 0);
        step(1, 1, 1, 1, 1, 1, 0);           // reset overrides everything
        // quarter: candy next cycle, one dime, back to idle
        step(0, 0, 0, 1, 0, 0, 0); idle(4, 0);
        // dime + nickel: exact price, no change; slot 0 now empty
        step(0, 0, 1, 0, 0, 0, 0); step(0, 1, 0, 0, 0, 0, 0); idle(3, 0);
        // slot 0 empty: quarter refunded as d,d,n; a dime during CHANGE bounces
        step(0, 0, 0, 1, 0, 0, 0); idle(2, 0); step(0, 0, 1, 0, 0, 0, 0); idle(4, 0);
        // nickel, nickel, cancel -> one dime back
        step(0, 1, 0, 0, 0, 0, 1); step(0, 1, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 1, 0, 1); idle(3, 1);
        // two coins at once, cancel in idle, cancel with coin
        step(0, 1, 1, 0, 0, 0, 1); step(0, 0, 0, 0, 1, 0, 1); step(0, 0, 1, 0, 1, 0, 1); idle(2, 1);
        // restock in idle then slot 0 vends again
        step(0, 0, 0, 0, 0, 1, 0); step(0, 0, 0, 1, 0, 0, 0); idle(4, 0);
        // sel beyond NUM_SLOTS -> sold_out with full refund
        step(0, 0, 0, 1, 0, 0, 3); idle(5, 3);
        // reset during the change pulse
        step(0, 0, 0, 1, 0, 0, 1); step(0, 0, 0, 0, 0, 0, 1); step(0, 0, 0, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0, 0, 1); idle(3, 1);
        // random traffic
        for (int i = 0; i < 1500; i++) begin
            int r = $urandom_range(0, 99);
            int s = $urandom_range(0, 3);
            bit rst = ($urandom_range(0, 199) == 0);
            case (1'b1)
                r < 12: step(rst, 1, 0, 0, 0, 0, s);
                r < 22: step(rst, 0, 1, 0, 0, 0, s);
                r < 30: step(rst, 0, 0, 1, 0, 0, s);
                r < 33: step(rst, 1, 0, 1, 0, 0, s);
                r < 37: step(rst, 0, 0, 0, 1, 0, s);
                r < 39: step(rst, 0, 0, 0, 0, 1, s);
                r < 40: step(rst, 0, 1, 0, 1, 0, s);
                default: step(rst, 0, 0, 0, 0, 0, s);
            endcase
        end
        idle(6, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/candy_vending_ctrl_p.md
Name: candy_vending_ctrl_p

Overview:
- Parametrised next-generation candy vending controller. Sits behind the DUT side of the candy vending interface.
- Accepts nickel/dime/quarter/cancel pulses and accumulates credit against a parametrised price.
- Selects one of NUM_SLOTS product slots, each with its own stock counter.
- Returns change serially as one dime (d) or nickel (n) pulse per cycle, replacing the fixed single-shot change of the previous machine.

Parameters:
- PRICE, 15, item price in cents; must be a multiple of 5 and >= 5
- NUM_SLOTS, 4, number of product slots; must be >= 1
- STOCK_INIT, 8, per-slot stock loaded at reset and on restock; must be >= 1
- SEL_W, $clog2(NUM_SLOTS) (minimum 1), slot select width
- STOCK_W, $clog2(STOCK_INIT+1), stock counter width

Ports:
- clock  in  1  system clock, all state updates on its rising edge
- reset  in  1  synchronous, active-high
- nickel  in  1  5c coin, one-cycle pulse
- dime  in  1  10c coin, one-cycle pulse
- quarter  in  1  25c coin, one-cycle pulse
- cancel  in  1  refund request, one-cycle pulse
- sel  in  SEL_W  slot select, sampled on the vend decision cycle
- restock  in  1  reload all slots to STOCK_INIT
- n  out  1  nickel change pulse
- d  out  1  dime change pulse
- candy  out  1  vend pulse, one cycle
- vend_slot  out  SEL_W  slot vended, valid while candy=1
- sold_out  out  1  one-cycle pulse: selected slot empty, full refund follows
- coin_err  out  1  one-cycle pulse: coin rejected
- busy  out  1  high in VEND or CHANGE state

Behaviour:
- Reset (sync, active-high) sets state IDLE, credit 0, change remainder 0, all stock counters = STOCK_INIT, and all outputs 0. Reset overrides all other inputs and aborts VEND/CHANGE mid-operation; no further n/d pulses are issued.
- Credit width is $clog2(PRICE+21). Credit never exceeds PRICE+20, because vending happens as soon as credit >= PRICE.
- FSM states: IDLE, CREDIT, VEND, CHANGE. All outputs are registered.
- IDLE/CREDIT, valid coin (exactly one of nickel/dime/quarter high): credit += 5/10/25 at the next edge. If the new credit >= PRICE, go to VEND; else go to (or stay in) CREDIT.
- More than one coin high in the same cycle: all are ignored, coin_err=1 next cycle, credit unchanged.
- Coin arriving in VEND or CHANGE: ignored, coin_err=1 next cycle.
- cancel in CREDIT: remainder = credit, credit = 0, go to CHANGE. cancel in IDLE is a no-op.
- cancel together with a coin: cancel wins, the coin is rejected (coin_err=1).
- VEND lasts exactly one cycle and samples sel.
  - stock[sel] > 0: candy=1, vend_slot=sel, stock[sel] -= 1, remainder = credit - PRICE.
  - stock[sel] == 0: sold_out=1, remainder = credit (full refund).
  - Then credit = 0; go to CHANGE if remainder > 0, else IDLE.
- Latency: the coin completing PRICE is sampled at edge t; candy is high during cycle t+1 to t+2; the first change pulse is high in the following cycle.
- sel >= NUM_SLOTS in VEND: treated as sold_out.
- CHANGE: one pulse per cycle, greedy. If remainder >= 10: d=1, remainder -= 10. Else if remainder == 5: n=1, remainder = 0. When remainder reaches 0, go to IDLE; n and d are 0 in the cycle after the last pulse.
- restock: honoured only in IDLE; all counters reload to STOCK_INIT. Ignored in all other states.
- Stock counters saturate at 0 and never wrap.

Optional Feature:
- Macro CV_REVENUE_CNT_EN.
- Defined: adds output port revenue [15:0]. Reset value 0. Increments by PRICE on every candy pulse and wraps modulo 2^16. Not cleared by restock.
- Undefined: the port and the counter do not exist. All other behaviour is identical.

Decomposition:
- Package cv_pkg holds:
  - localparams NICKEL_VAL=5, DIME_VAL=10, QUARTER_VAL=25
  - typedef enum logic [1:0] cv_state_t {IDLE, CREDIT, VEND, CHANGE}
  - function coin_value(nickel, dime, quarter), which returns 0 for an illegal combination
- Sub-module cv_change_dispenser takes load/remainder in and drives n, d and done. It owns the CHANGE-state remainder register.

Test Plan:
- PRICE=15: quarter at edge t → candy=1 at t+1, d=1 at t+2, idle at t+3 with busy=0; no n pulse.
- dime, then nickel → candy=1 one cycle after the nickel; no n/d; stock[sel] goes 8→7.
- nickel, nickel, cancel → one d pulse; candy never asserted; credit 0.
- NUM_SLOTS=4, STOCK_INIT=1, sel=2: first quarter → candy plus d; second quarter → sold_out=1, then d, d, n (25c refunded); stock[2] stays 0. restock in IDLE → next quarter vends.
- nickel and dime in the same cycle → coin_err=1, credit stays 0. A dime during CHANGE → coin_err=1, change sequence unaffected.
- Quarter then reset during the d pulse → all outputs 0 the next cycle, credit 0, stock = STOCK_INIT, no further pulses.
